mem_wb_skid_reg: RTL and testbench

//   Parametrised MEM->WB pipeline register with a valid/ready handshake, a 2-entry skid

---
 rtl/mem_wb_skid_reg.sv | 68 ++++++
 tb/tb_mem_wb_skid_reg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg: MEM->WB pipeline register with 2-entry skid buffer, flush and saturating stall counter
module mem_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rd_val,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_mem_rd_val,
  output logic [DEST_W-1:0] out_dest,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int E_W = 2 + 2 * DATA_W + DEST_W;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, nxt;
  logic [E_W-1:0] in_e, main_e, skid_e;
  logic rdy_q, accept, consume, load_main, load_skid;
  logic main_wb_en, main_mem_r_en;
  assign in_e = {in_wb_en, in_mem_r_en, in_alu_result, in_mem_rd_val, in_dest};
  assign {main_wb_en, main_mem_r_en, out_alu_result, out_mem_rd_val, out_dest} = main_e;
  assign in_ready = rdy_q & ~rst;
  assign out_valid = state != EMPTY;
  assign out_wb_en = main_wb_en & out_valid;
  assign out_mem_r_en = main_mem_r_en & out_valid;
  assign accept = in_valid & in_ready;
  assign consume = out_valid & out_ready;
  // next state and entry movement; flush drops everything, including an entry offered this cycle
  always_comb begin
    nxt = flush ? EMPTY :
          state == EMPTY ? (accept ? ONE : EMPTY) :
          state == ONE ? (accept & ~consume ? TWO : ~accept & consume ? EMPTY : ONE) :
          (consume ? ONE : TWO);
    load_main = ~flush & ((state == EMPTY & accept) | (state == ONE & accept & consume) | (state == TWO & consume));
    load_skid = ~flush & state == ONE & accept & ~consume;
  end
  // state, registered in_ready and entry storage; data fields hold unless loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      rdy_q  <= 1'b0;
      main_e <= '0;
      skid_e <= '0;
    end else begin
      state <= nxt;
      rdy_q <= nxt != TWO;
      if (load_main) main_e <= state == TWO ? skid_e : in_e;
      if (load_skid) skid_e <= in_e;
    end
  end
  // count cycles where the WB stage holds off a valid entry, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// tb_mem_wb_skid_reg: randomized self-checking bench for mem_wb_skid_reg against a queue model
module tb_mem_wb_skid_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {
    bit wb;
    bit mr;
    logic [DW-1:0] alu;
    logic [DW-1:0] rd;
    logic [AW-1:0] dest;
  } entry_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_wb_en = 0, in_mem_r_en = 0, out_ready = 0;
  logic [DW-1:0] in_alu_result = 0, in_mem_rd_val = 0;
  logic [AW-1:0] in_dest = 0;
  logic in_ready, out_valid, out_wb_en, out_mem_r_en;
  logic [DW-1:0] out_alu_result, out_mem_rd_val;
  logic [AW-1:0] out_dest;
  logic [CW-1:0] stall_cnt;
  int checks = 0, errors = 0;
  entry_t q[$];
  entry_t disp;
  bit rdy_m;
  int cnt_m;

  mem_wb_skid_reg #(.DATA_W(DW), .DEST_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_alu_result(in_alu_result),
    .in_mem_rd_val(in_mem_rd_val), .in_dest(in_dest), .out_valid(out_valid),
    .out_ready(out_ready), .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en),
    .out_alu_result(out_alu_result), .out_mem_rd_val(out_mem_rd_val),
    .out_dest(out_dest), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    disp = '{0, 0, '0, '0, '0};
    rdy_m = 0;
    cnt_m = 0;
  endtask

  task automatic tick();
    entry_t e;
    bit acc, con;
    if (!rst) begin
      acc = in_valid && rdy_m;
      con = q.size() > 0 && out_ready;
      if (q.size() > 0 && !out_ready && cnt_m < CMAX) cnt_m++;
      e = '{in_wb_en, in_mem_r_en, in_alu_result, in_mem_rd_val, in_dest};
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      rdy_m = q.size() < 2;
      if (q.size() > 0) disp = q[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] d, input bit wb);
    in_valid = v;
    in_dest = d;
    in_wb_en = wb;
    in_mem_r_en = 1'($urandom);
    in_alu_result = $urandom;
    in_mem_rd_val = $urandom;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({in_ready, out_valid, out_wb_en, out_mem_r_en, out_alu_result, out_mem_rd_val, out_dest, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b wb=%b mr=%b alu=%h rd=%h dest=%h cnt=%0d, expected all zero",
               in_ready, out_valid, out_wb_en, out_mem_r_en, out_alu_result, out_mem_rd_val, out_dest, stall_cnt);
    end
    rst = 0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_release: got %b expected 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      drive(1, AW'(i), 1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_dest !== AW'(i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b dest=%0d rdy=%b expected v=1 dest=%0d rdy=1", i, out_valid, out_dest, in_ready, i);
      end
    end
    drive(0, 0, 0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL stream_end: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    drive(1, 3, 1);
    tick();
    drive(1, 4, 1);
    tick();
    drive(0, 0, 0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_dest !== AW'(3)) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b v=%b dest=%0d expected rdy=0 v=1 dest=3", in_ready, out_valid, out_dest);
    end
    out_ready = 1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_dest !== AW'(4)) begin
      errors++;
      $display("FAIL bp_drain: got rdy=%b v=%b dest=%0d expected rdy=1 v=1 dest=4", in_ready, out_valid, out_dest);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== CW'(cnt_m)) begin
      errors++;
      $display("FAIL bp_empty: got v=%b cnt=%0d expected v=0 cnt=%0d", out_valid, stall_cnt, cnt_m);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(1, 5, 1);
    tick();
    drive(1, 6, 1);
    tick();
    drive(1, 9, 1);
    flush = 1;
    tick();
    flush = 0;
    drive(0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || out_wb_en !== 1'b0 || in_ready !== 1'b1 || out_dest !== AW'(5)) begin
      errors++;
      $display("FAIL flush: got v=%b wb=%b rdy=%b dest=%0d expected v=0 wb=0 rdy=1 dest=5", out_valid, out_wb_en, in_ready, out_dest);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_%0d: got v=%b dest=%0d expected v=0", i, out_valid, out_dest); end
    end
  endtask

  task automatic test_bubble();
    out_ready = 1;
    drive(1, 17, 1);
    tick();
    checks++;
    if (out_wb_en !== 1'b1 || out_dest !== AW'(17)) begin
      errors++;
      $display("FAIL bubble_live: got wb=%b dest=%0d expected wb=1 dest=17", out_wb_en, out_dest);
    end
    drive(0, 0, 0);
    tick();
    checks++;
    if (out_wb_en !== 1'b0 || out_mem_r_en !== 1'b0 || out_valid !== 1'b0 || out_dest !== AW'(17)) begin
      errors++;
      $display("FAIL bubble_gate: got wb=%b mr=%b v=%b dest=%0d expected wb=0 mr=0 v=0 dest=17", out_wb_en, out_mem_r_en, out_valid, out_dest);
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 0;
    drive(1, 2, 0);
    tick();
    drive(0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (stall_cnt !== CW'(i < CMAX ? i : CMAX)) begin
        errors++;
        $display("FAIL stall_%0d: got %0d expected %0d", i, stall_cnt, i < CMAX ? i : CMAX);
      end
    end
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if (stall_cnt !== CW'(CMAX)) begin errors++; $display("FAIL stall_flush: got %0d expected %0d", stall_cnt, CMAX); end
    do_reset();
    checks++;
    if (stall_cnt !== '0) begin errors++; $display("FAIL stall_rst: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    drive(1, 7, 1);
    tick();
    drive(1, 8, 1);
    tick();
    drive(0, 0, 0);
    #2;
    rst = 1;
    model_reset();
    #1;
    checks++;
    if ({in_ready, out_valid, out_wb_en, out_mem_r_en, out_alu_result, out_mem_rd_val, out_dest, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL async_rst: got rdy=%b v=%b wb=%b mr=%b alu=%h rd=%h dest=%h cnt=%0d, expected all zero",
               in_ready, out_valid, out_wb_en, out_mem_r_en, out_alu_result, out_mem_rd_val, out_dest, stall_cnt);
    end
    @(posedge clk);
    #1;
    rst = 0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_release: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), AW'($urandom), 1'($urandom));
      out_ready = 1'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== rdy_m || out_dest !== disp.dest ||
          out_alu_result !== disp.alu || out_mem_rd_val !== disp.rd ||
          out_wb_en !== (q.size() > 0 && disp.wb) || out_mem_r_en !== (q.size() > 0 && disp.mr) ||
          stall_cnt !== CW'(cnt_m)) begin
        errors++;
        $display("FAIL random_%0d: got v=%b rdy=%b dest=%0d alu=%h rd=%h wb=%b mr=%b cnt=%0d expected v=%b rdy=%b dest=%0d alu=%h rd=%h wb=%b mr=%b cnt=%0d",
                 i, out_valid, in_ready, out_dest, out_alu_result, out_mem_rd_val, out_wb_en, out_mem_r_en, stall_cnt,
                 q.size() > 0, rdy_m, disp.dest, disp.alu, disp.rd, q.size() > 0 && disp.wb, q.size() > 0 && disp.mr, cnt_m);
      end
    end
    flush = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_bubble();
    test_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
